// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder arbiter and its adder core.
package fp_pkg;
   localparam int FP_W    = 32;
   localparam int EXP_MSB = 30;
   localparam int EXP_LSB = 23;
   localparam int MAN_W   = 23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Implicit leading one is present only for a nonzero exponent.
   function automatic logic hidden_bit(input logic [EXP_MSB-EXP_LSB:0] e);
      return |e;
   endfunction
endpackage

// File: rtl/floating_point_adder.sv
// Combinational single-precision adder: align, add/subtract, normalise, truncate.
// Results below the normal range flush to zero; overflow saturates to infinity.
module floating_point_adder
   import fp_pkg::*;
(
   input  logic [FP_W-1:0] opa,
   input  logic [FP_W-1:0] opb,
   output logic [FP_W-1:0] sum
);
   localparam int EW = EXP_MSB - EXP_LSB + 1;
   localparam int SW = MAN_W + 5;  // carry + hidden + fraction + 3 guard bits

   logic           sl, ss;
   logic [EW-1:0]  el, es;
   logic [MAN_W:0] ml, ms;
   logic [SW-1:0]  al, as_sh, s, norm;
   logic           unused_norm;
   int             msb, e_i;

   // Larger magnitude operand sets sign and exponent; the smaller one is shifted to align.
   always_comb begin
      if (opa[FP_W-2:0] >= opb[FP_W-2:0]) begin
         sl = opa[FP_W-1]; el = opa[EXP_MSB:EXP_LSB]; ml = {hidden_bit(opa[EXP_MSB:EXP_LSB]), opa[MAN_W-1:0]};
         ss = opb[FP_W-1]; es = opb[EXP_MSB:EXP_LSB]; ms = {hidden_bit(opb[EXP_MSB:EXP_LSB]), opb[MAN_W-1:0]};
      end else begin
         sl = opb[FP_W-1]; el = opb[EXP_MSB:EXP_LSB]; ml = {hidden_bit(opb[EXP_MSB:EXP_LSB]), opb[MAN_W-1:0]};
         ss = opa[FP_W-1]; es = opa[EXP_MSB:EXP_LSB]; ms = {hidden_bit(opa[EXP_MSB:EXP_LSB]), opa[MAN_W-1:0]};
      end
      al    = {1'b0, ml, 3'b000};
      as_sh = {1'b0, ms, 3'b000} >> (el - es);
      s     = (sl == ss) ? al + as_sh : al - as_sh;
      msb   = -1;
      for (int i = 0; i < SW; i++) begin
         if (s[i]) msb = i;
      end
      norm = s;
      e_i  = 0;
      if (msb == SW-1) begin
         norm = s >> 1;
         e_i  = int'(el) + 1;
      end else if (msb >= 0) begin
         norm = s << (SW-2-msb);
         e_i  = int'(el) - (SW-2-msb);
      end
      if (msb < 0 || e_i <= 0) sum = '0;
      else if (e_i >= (1 << EW) - 1) sum = {sl, {EW{1'b1}}, {MAN_W{1'b0}}};
      else sum = {sl, e_i[EW-1:0], norm[SW-3:3]};
   end

   assign unused_norm = ^{norm[SW-1:SW-2], norm[2:0]};
endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP adder among NUM_REQ requesters, one op in flight.
module fp_add_arbiter
   import fp_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*FP_W-1:0] req_opa,
   input  logic [NUM_REQ*FP_W-1:0] req_opb,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [FP_W-1:0]         res_data,
   output logic [IDW-1:0]          res_id,
   output logic                    busy,
   output logic [15:0]             op_count
);
   state_t          state, state_nxt;
   logic [IDW-1:0]  rr_ptr, gnt_idx, id_q;
   logic            gnt_any, accept;
   logic [FP_W-1:0] opa_q, opb_q, sum;

   // Round-robin search from rr_ptr; scanning backwards lets the nearest valid win.
   always_comb begin
      int j;
      j       = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = NUM_REQ-1; k >= 0; k--) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (req_valid[j]) begin
            gnt_any = 1'b1;
            gnt_idx = IDW'(j);
         end
      end
   end

   // Ready is offered only to the granted requester, only in IDLE, never during reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign accept    = |(req_valid & req_ready);
   assign res_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Operand capture, result register, pointer advance and handshake counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr   <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         id_q     <= '0;
         res_data <= '0;
         res_id   <= '0;
         op_count <= '0;
      end else begin
         if (state == IDLE && accept) begin
            opa_q  <= req_opa[gnt_idx*FP_W +: FP_W];
            opb_q  <= req_opb[gnt_idx*FP_W +: FP_W];
            id_q   <= gnt_idx;
            rr_ptr <= (int'(gnt_idx) == NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
         end
         if (state == EXEC) begin
            res_data <= sum;
            res_id   <= id_q;
         end
         if (state == RESP && res_ready) op_count <= op_count + 16'd1;
      end
   end

   floating_point_adder u_add (
      .opa (opa_q),
      .opb (opb_q),
      .sum (sum)
   );
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: expected results queued at drive time,
// checked as the result handshake happens.
module tb_fp_add_arbiter;
   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready;
   logic [N*32-1:0] req_opa, req_opb;
   logic            res_valid, res_ready, busy;
   logic [31:0]     res_data;
   logic [0:0]      res_id;
   logic [15:0]     op_count;

   typedef struct {
      logic [0:0]  id;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fp_add_arbiter #(.NUM_REQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_opa   (req_opa),
      .req_opb   (req_opb),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Result monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("res_data", res_data, e.data);
            chk("res_id", 32'(res_id), 32'(e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int r, input logic [31:0] a, input logic [31:0] b);
      req_opa[r*32 +: 32] = a;
      req_opb[r*32 +: 32] = b;
   endtask

   task automatic push(input logic [0:0] id, input logic [31:0] d);
      sb.push_back(exp_t'{id, d});
   endtask

   task automatic do_reset();
      tick();
      rst_n = 1'b0; req_valid = '1; res_ready = 1'b1;
      sb.delete();
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_resv", 32'(res_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(op_count), 0);
      chk("rst_data", res_data, 0);
      chk("rst_id", 32'(res_id), 0);
      tick();
      req_valid = '0; rst_n = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      chk("drain", 32'(sb.size()), 0);
      tick();
      @(negedge clk);
   endtask

   // Single request on requester 0 with latency checks; res_ready assumed high.
   task automatic one(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      tick(); set_op(0, a, b); req_valid[0] = 1'b1; push(1'b0, e);
      @(negedge clk);
      chk("t0_ready", 32'(req_ready), 1);
      chk("t0_busy", 32'(busy), 0);
      tick(); req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_resv", 32'(res_valid), 0);
      chk("t1_ready", 32'(req_ready), 0);
      tick(); @(negedge clk);
      chk("t2_resv", 32'(res_valid), 1);
      tick(); @(negedge clk);
      chk("t3_busy", 32'(busy), 0);
   endtask

   // Both requesters valid together: 0 must go first, 1 three cycles later.
   task automatic pair(input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] e1);
      tick(); set_op(0, a0, b0); set_op(1, a1, b1); req_valid = 2'b11;
      push(1'b0, e0); push(1'b1, e1);
      @(negedge clk); chk("pair_first", 32'(req_ready), 1);
      tick(); req_valid[0] = 1'b0;
      @(negedge clk); chk("pair_exec_ready", 32'(req_ready), 0);
      tick(); @(negedge clk);
      chk("pair_resp_ready", 32'(req_ready), 0);
      chk("pair_resv", 32'(res_valid), 1);
      tick(); @(negedge clk); chk("pair_second", 32'(req_ready), 2);
      tick(); req_valid[1] = 1'b0;
      drain();
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; res_ready = 1'b1; req_opa = '0; req_opb = '0;

      // 1.0 + 2.0 = 3.0 on requester 0
      do_reset();
      one(32'h3F800000, 32'h40000000, 32'h40400000);
      chk("basic_data", res_data, 32'h40400000);
      chk("basic_count", 32'(op_count), 1);

      // simultaneous requests after reset: ids 0 then 1
      do_reset();
      pair(32'h3FC00000, 32'h40100000, 32'h40700000,
           32'h41200000, 32'h3F000000, 32'h41280000);
      chk("pair_count", 32'(op_count), 2);

      // back-pressure in RESP for 5 cycles; 5 + -3 = 2
      do_reset();
      tick(); set_op(0, 32'h40A00000, 32'hC0400000); req_valid[0] = 1'b1; push(1'b0, 32'h40000000);
      @(negedge clk); chk("bp_t0_ready", 32'(req_ready), 1);
      tick(); req_valid = 2'b10; res_ready = 1'b0; set_op(1, 32'h40400000, 32'hC0400000);
      @(negedge clk); chk("bp_exec_ready", 32'(req_ready), 0);
      for (int k = 0; k < 5; k++) begin
         if (k != 0) tick();
         else tick();
         @(negedge clk);
         chk("bp_resv", 32'(res_valid), 1);
         chk("bp_data", res_data, 32'h40000000);
         chk("bp_id", 32'(res_id), 0);
         chk("bp_ready", 32'(req_ready), 0);
         chk("bp_busy", 32'(busy), 1);
         chk("bp_count", 32'(op_count), 0);
      end
      push(1'b1, 32'h00000000);
      tick(); res_ready = 1'b1;
      @(negedge clk);
      tick(); @(negedge clk); chk("bp_next_grant", 32'(req_ready), 2);
      tick(); req_valid = '0;
      drain();
      chk("bp_final_count", 32'(op_count), 2);

      // reset during EXEC discards the op; next grant goes to requester 0
      do_reset();
      tick(); set_op(0, 32'h42C80000, 32'h3F800000); req_valid[0] = 1'b1;
      @(negedge clk); chk("rx_t0_ready", 32'(req_ready), 1);
      tick(); req_valid = '0;
      @(negedge clk); chk("rx_exec_busy", 32'(busy), 1);
      tick(); rst_n = 1'b0;
      @(negedge clk);
      chk("rx_resv", 32'(res_valid), 0);
      chk("rx_busy", 32'(busy), 0);
      chk("rx_count", 32'(op_count), 0);
      tick(); rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rx_quiet_resv", 32'(res_valid), 0);
         chk("rx_quiet_busy", 32'(busy), 0);
         tick();
      end
      pair(32'h42C80000, 32'h3F800000, 32'h42CA0000,
           32'h3F800000, 32'h40000000, 32'h40400000);
      chk("rx_count_after", 32'(op_count), 2);

      // op_count wrap from 0xFFFF
      do_reset();
      tick(); force dut.op_count = 16'hFFFF;
      @(negedge clk); release dut.op_count;
      #1 chk("wrap_pre", 32'(op_count), 32'h0000FFFF);
      one(32'h3F800000, 32'h40000000, 32'h40400000);
      chk("wrap_post", 32'(op_count), 0);

      // req1 continuously valid, req0 pulses valid only while busy
      do_reset();
      begin
         logic [31:0] ta [3];
         logic [31:0] tb [3];
         logic [31:0] te [3];
         ta = '{32'h3FC00000, 32'h41200000, 32'h3F800000};
         tb = '{32'h40100000, 32'h3F000000, 32'h40000000};
         te = '{32'h40700000, 32'h41280000, 32'h40400000};
         for (int k = 0; k < 9; k++) begin
            tick();
            if (k % 3 == 0) begin
               set_op(1, ta[k/3], tb[k/3]);
               req_valid[1] = 1'b1;
               push(1'b1, te[k/3]);
            end
            if (k == 1) req_valid[0] = 1'b1;
            if (k == 2) req_valid[0] = 1'b0;
            @(negedge clk);
            chk("skip_ready", 32'(req_ready), (k % 3 == 0) ? 2 : 0);
         end
      end
      tick(); set_op(0, 32'h40A00000, 32'hC0400000); req_valid = 2'b11; push(1'b0, 32'h40000000);
      @(negedge clk); chk("skip_ptr_kept", 32'(req_ready), 1);
      tick(); req_valid = '0;
      drain();
      chk("skip_count", 32'(op_count), 4);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
